// File: rtl/fft_seq_pkg.sv
// Shared types and field positions for the FFT job sequencer.
package fft_seq_pkg;

  // State encodings are visible in status[7:4], so they are fixed.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StLaunch  = 3'd2,
    StRun     = 3'd3,
    StCapture = 3'd4
  } seq_state_e;

  // GPR control word bit indices.
  localparam int unsigned GprStartBit = 0;
  localparam int unsigned GprAbortBit = 1;
  localparam int unsigned GprIrqEnBit = 2;

  // Status word field positions.
  localparam int unsigned StBusyBit    = 0;
  localparam int unsigned StDoneBit    = 1;
  localparam int unsigned StTimeoutBit = 2;
  localparam int unsigned StAbortedBit = 3;
  localparam int unsigned StStateLsb   = 4;
  localparam int unsigned StStateW     = 4;
  localparam int unsigned StCountLsb   = 8;

  localparam int unsigned RunCountW = 8;

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Host write port of the shared memory map, as seen through the sequencer's gate.
interface fft_seq_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  host_write_en;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic                  host_stall;
  logic                  mm_write_en;

  // Host side drives the request and observes the stall / gated enable.
  modport master (
    output host_write_en,
    output host_addr,
    input  host_stall,
    input  mm_write_en
  );

  // Sequencer side decides whether the write reaches the memory map.
  modport slave (
    input  host_write_en,
    input  host_addr,
    output host_stall,
    output mm_write_en
  );
endinterface

// File: rtl/fft_seq_ctrl_seq_timer.sv
// Loadable up-counter with terminal-count flag, shared by SETTLE and RUN.
module seq_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] tc_value_i,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  // Clear has priority so every state entry starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == tc_value_i);

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequences one FFT job: settle, launch, wait with timeout, capture; gates host writes.
module fft_seq_ctrl
  import fft_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned FFT_IN_BASE    = 31,
  parameter int unsigned FFT_IN_REGS    = 16,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpr_ctrl,
  fft_seq_ctrl_if.slave         host,
  output logic                  fft_start,
  output logic                  fft_abort,
  input  logic                  core_done,
  output logic                  fft_done,
  output logic [DATA_WIDTH-1:0] status,
  output logic                  irq
);

  localparam int unsigned TimerMax =
      (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TimerW = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  seq_state_e           state_q, state_d;
  logic                 start_q;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 aborted_q, aborted_d;
  logic [RunCountW-1:0] run_count_q, run_count_d;
  logic                 fft_start_q, fft_abort_q, fft_done_q;
  logic                 abort_pulse_d;

  logic                 start_edge, abort_req, irq_en;
  logic                 timer_tc, timer_clear, timer_en;
  logic [TimerW-1:0]    timer_tc_value;

  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           addr_ext;
  logic                  in_range;
  logic                  unused_gpr;

  assign start_edge = gpr_ctrl[GprStartBit] & ~start_q;
  assign abort_req  = gpr_ctrl[GprAbortBit];
  assign irq_en     = gpr_ctrl[GprIrqEnBit];
  assign unused_gpr = ^gpr_ctrl[DATA_WIDTH-1:3];

  // Timer restarts on every state change and only runs where it is meaningful.
  assign timer_clear    = (state_d != state_q);
  assign timer_en       = (state_q == StSettle) || (state_q == StRun);
  assign timer_tc_value = (state_q == StRun) ? TimerW'(TIMEOUT_CYCLES - 1)
                                             : TimerW'(SETTLE_CYCLES - 1);

  seq_timer #(
    .Width (TimerW)
  ) u_seq_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear),
    .en_i       (timer_en),
    .tc_value_i (timer_tc_value),
    .tc_o       (timer_tc)
  );

  // Next-state, sticky-flag and pulse-request logic.
  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    aborted_d     = aborted_q;
    run_count_d   = run_count_q;
    abort_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // ABORT beats a coincident START edge.
        if (start_edge && !abort_req) begin
          state_d   = StSettle;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
        end
      end
      StSettle: begin
        // Core never started, so no abort pulse is needed.
        if (abort_req) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (timer_tc) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StRun;
      end
      StRun: begin
        if (core_done) begin
          state_d = StCapture;
        end else if (abort_req) begin
          state_d       = StIdle;
          aborted_d     = 1'b1;
          abort_pulse_d = 1'b1;
        end else if (timer_tc) begin
          state_d       = StIdle;
          timeout_d     = 1'b1;
          abort_pulse_d = 1'b1;
        end
      end
      StCapture: begin
        state_d     = StIdle;
        done_d      = 1'b1;
        run_count_d = run_count_q + RunCountW'(1);
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, sticky flags and registered state-decoded pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      aborted_q   <= 1'b0;
      run_count_q <= '0;
      fft_start_q <= 1'b0;
      fft_abort_q <= 1'b0;
      fft_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= gpr_ctrl[GprStartBit];
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      aborted_q   <= aborted_d;
      run_count_q <= run_count_d;
      fft_start_q <= (state_d == StLaunch);
      fft_abort_q <= abort_pulse_d;
      fft_done_q  <= (state_d == StCapture);
    end
  end

  assign fft_start = fft_start_q;
  assign fft_abort = fft_abort_q;
  assign fft_done  = fft_done_q;

  // Host-write gate: protect FFT inputs while busy and keep the capture cycle write-free.
  assign addr     = host.host_addr;
  assign addr_ext = 32'(addr);
  assign in_range = (addr_ext >= FFT_IN_BASE) && (addr_ext < FFT_IN_BASE + FFT_IN_REGS);

  assign host.host_stall  = host.host_write_en &
                            ((state_q == StCapture) || ((state_q != StIdle) && in_range));
  assign host.mm_write_en = host.host_write_en & ~host.host_stall;

  // Status word assembly; unused upper bits stay zero.
  always_comb begin
    status                              = '0;
    status[StBusyBit]                   = (state_q != StIdle);
    status[StDoneBit]                   = done_q;
    status[StTimeoutBit]                = timeout_q;
    status[StAbortedBit]                = aborted_q;
    status[StStateLsb +: StStateW]      = {1'b0, state_q};
    status[StCountLsb +: RunCountW]     = run_count_q;
  end

  assign irq = irq_en & (done_q | timeout_q | aborted_q);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl with SETTLE_CYCLES=2, TIMEOUT_CYCLES=8.
module tb_fft_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpr_ctrl;
  logic        core_done;
  logic        fft_start, fft_abort, fft_done, irq;
  logic [15:0] status;

  int passed = 0;
  int total  = 0;

  fft_seq_ctrl_if #(.ADDR_WIDTH(6)) hif ();

  fft_seq_ctrl #(
    .DATA_WIDTH     (16),
    .ADDR_WIDTH     (6),
    .FFT_IN_BASE    (31),
    .FFT_IN_REGS    (16),
    .SETTLE_CYCLES  (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gpr_ctrl  (gpr_ctrl),
    .host      (hif),
    .fft_start (fft_start),
    .fft_abort (fft_abort),
    .core_done (core_done),
    .fft_done  (fft_done),
    .status    (status),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Advance one clock; observe and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // START edge now; returns in the first RUN cycle with START released.
  task automatic go_to_run(input logic [15:0] ctrl);
    gpr_ctrl = ctrl;
    repeat (4) step();
    gpr_ctrl = ctrl & 16'hfffe;
  endtask

  task automatic test_reset();
    rst = 1'b1; gpr_ctrl = '0; core_done = 1'b0;
    hif.host_write_en = 1'b1; hif.host_addr = 6'd35;
    step(); step();
    total++; if (status !== 16'h0000) $display("FAIL reset_status got %h want 0000", status); else passed++;
    total++; if ({fft_start, fft_abort, fft_done, irq} !== 4'b0000)
      $display("FAIL reset_pulses got %b want 0000", {fft_start, fft_abort, fft_done, irq}); else passed++;
    total++; if ({hif.host_stall, hif.mm_write_en} !== 2'b01)
      $display("FAIL reset_gate got %b want 01", {hif.host_stall, hif.mm_write_en}); else passed++;
    rst = 1'b0; hif.host_write_en = 1'b0;
    step();
  endtask

  task automatic test_normal();
    gpr_ctrl = 16'h0005;                    // cycle N: START edge, IRQ_EN
    step();                                 // N+1
    total++; if (status !== 16'h0011) $display("FAIL normal_settle got %h want 0011", status); else passed++;
    step(); step();                         // N+3
    total++; if (fft_start !== 1'b1 || status[7:4] !== 4'd2)
      $display("FAIL normal_launch got start=%b st=%0d want 1/2", fft_start, status[7:4]); else passed++;
    step();                                 // N+4 first RUN cycle
    total++; if (fft_start !== 1'b0 || status[7:4] !== 4'd3)
      $display("FAIL normal_run got start=%b st=%0d want 0/3", fft_start, status[7:4]); else passed++;
    repeat (6) step();                      // M = N+10
    core_done = 1'b1;
    step();                                 // M+1
    core_done = 1'b0;
    total++; if (fft_done !== 1'b1 || status[7:4] !== 4'd4)
      $display("FAIL normal_capture got done=%b st=%0d want 1/4", fft_done, status[7:4]); else passed++;
    step();                                 // M+2
    total++; if (status !== 16'h0102 || fft_done !== 1'b0)
      $display("FAIL normal_status got %h done=%b want 0102/0", status, fft_done); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL normal_irq_on got %b want 1", irq); else passed++;
    gpr_ctrl = 16'h0001; #1;
    total++; if (irq !== 1'b0) $display("FAIL normal_irq_off got %b want 0", irq); else passed++;
    gpr_ctrl = '0;
    step();
  endtask

  task automatic test_host_gating();
    go_to_run(16'h0001);
    hif.host_write_en = 1'b1;
    hif.host_addr = 6'd35; #1;
    total++; if ({hif.host_stall, hif.mm_write_en} !== 2'b10)
      $display("FAIL gate_run_in got %b want 10", {hif.host_stall, hif.mm_write_en}); else passed++;
    hif.host_addr = 6'd5; #1;
    total++; if ({hif.host_stall, hif.mm_write_en} !== 2'b01)
      $display("FAIL gate_run_gpr got %b want 01", {hif.host_stall, hif.mm_write_en}); else passed++;
    hif.host_addr = 6'd30; #1;
    total++; if (hif.host_stall !== 1'b0) $display("FAIL gate_below_base got %b want 0", hif.host_stall); else passed++;
    hif.host_addr = 6'd31; #1;
    total++; if (hif.host_stall !== 1'b1) $display("FAIL gate_base got %b want 1", hif.host_stall); else passed++;
    hif.host_addr = 6'd46; #1;
    total++; if (hif.host_stall !== 1'b1) $display("FAIL gate_top got %b want 1", hif.host_stall); else passed++;
    hif.host_addr = 6'd47; #1;
    total++; if (hif.host_stall !== 1'b0) $display("FAIL gate_past_top got %b want 0", hif.host_stall); else passed++;
    hif.host_addr = 6'd35;
    core_done = 1'b1;
    step();                                 // CAPTURE
    core_done = 1'b0;
    total++; if ({hif.host_stall, hif.mm_write_en} !== 2'b10)
      $display("FAIL gate_capture_in got %b want 10", {hif.host_stall, hif.mm_write_en}); else passed++;
    hif.host_addr = 6'd5; #1;
    total++; if ({hif.host_stall, hif.mm_write_en} !== 2'b10)
      $display("FAIL gate_capture_gpr got %b want 10", {hif.host_stall, hif.mm_write_en}); else passed++;
    hif.host_addr = 6'd35;
    step();                                 // first IDLE cycle
    total++; if ({hif.host_stall, hif.mm_write_en} !== 2'b01)
      $display("FAIL gate_release got %b want 01", {hif.host_stall, hif.mm_write_en}); else passed++;
    hif.host_write_en = 1'b0; #1;
    total++; if (hif.mm_write_en !== 1'b0) $display("FAIL gate_no_req got %b want 0", hif.mm_write_en); else passed++;
    step();
  endtask

  task automatic test_timeout();
    int   run_cycles;
    logic saw_done;
    run_cycles = 0;
    saw_done   = 1'b0;
    go_to_run(16'h0001);
    for (int i = 0; i < 8; i++) begin
      if (status[7:4] == 4'd3) run_cycles++;
      if (fft_done === 1'b1 || fft_abort === 1'b1) saw_done = 1'b1;
      step();
    end
    total++; if (run_cycles != 8) $display("FAIL timeout_run_len got %0d want 8", run_cycles); else passed++;
    total++; if (saw_done !== 1'b0) $display("FAIL timeout_early_pulse got %b want 0", saw_done); else passed++;
    total++; if (fft_abort !== 1'b1 || fft_done !== 1'b0)
      $display("FAIL timeout_abort got abort=%b done=%b want 1/0", fft_abort, fft_done); else passed++;
    total++; if (status !== 16'h0204) $display("FAIL timeout_status got %h want 0204", status); else passed++;
    step();
    total++; if (fft_abort !== 1'b0) $display("FAIL timeout_abort_width got %b want 0", fft_abort); else passed++;
  endtask

  task automatic test_abort();
    logic saw_pulse;
    saw_pulse = 1'b0;
    go_to_run(16'h0001);
    step();
    gpr_ctrl = 16'h0002;
    step();
    total++; if (fft_abort !== 1'b1 || status !== 16'h0208)
      $display("FAIL abort_run got abort=%b st=%h want 1/0208", fft_abort, status); else passed++;
    gpr_ctrl = '0;
    step();
    total++; if (fft_abort !== 1'b0) $display("FAIL abort_run_width got %b want 0", fft_abort); else passed++;
    gpr_ctrl = 16'h0001;                    // new job, clears aborted
    step();
    total++; if (status !== 16'h0211) $display("FAIL abort_settle_entry got %h want 0211", status); else passed++;
    gpr_ctrl = 16'h0002;
    step();
    total++; if (status !== 16'h0208) $display("FAIL abort_settle got %h want 0208", status); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (fft_start === 1'b1 || fft_abort === 1'b1) saw_pulse = 1'b1;
      step();
    end
    total++; if (saw_pulse !== 1'b0) $display("FAIL abort_settle_pulse got %b want 0", saw_pulse); else passed++;
    gpr_ctrl = '0;
    step();
  endtask

  task automatic test_back_to_back();
    go_to_run(16'h0001);
    gpr_ctrl = 16'h0001;                    // START edge inside RUN
    step();
    gpr_ctrl = '0;
    step();
    total++; if (status[7:4] !== 4'd3) $display("FAIL b2b_still_run got %0d want 3", status[7:4]); else passed++;
    core_done = 1'b1;
    gpr_ctrl  = 16'h0002;
    step();                                 // CAPTURE, ABORT still held
    core_done = 1'b0;
    total++; if (fft_done !== 1'b1 || fft_abort !== 1'b0)
      $display("FAIL b2b_capture got done=%b abort=%b want 1/0", fft_done, fft_abort); else passed++;
    step();
    total++; if (status !== 16'h0302 || fft_abort !== 1'b0)
      $display("FAIL b2b_status got %h abort=%b want 0302/0", status, fft_abort); else passed++;
    gpr_ctrl = '0;
    repeat (3) step();
    total++; if (status !== 16'h0302) $display("FAIL b2b_single_count got %h want 0302", status); else passed++;
  endtask

  task automatic test_wrap();
    for (int j = 0; j < 253; j++) begin
      gpr_ctrl = 16'h0001;
      repeat (4) step();
      gpr_ctrl  = '0;
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      step();
      if (j == 251) begin
        total++; if (status[15:8] !== 8'd255)
          $display("FAIL wrap_255 got %0d want 255", status[15:8]); else passed++;
      end
    end
    total++; if (status !== 16'h0002) $display("FAIL wrap_zero got %h want 0002", status); else passed++;
  endtask

  task automatic test_reset_mid_run();
    go_to_run(16'h0005);
    step();
    rst = 1'b1;
    step();
    total++; if (status !== 16'h0000) $display("FAIL rstrun_status got %h want 0000", status); else passed++;
    total++; if ({fft_start, fft_abort, fft_done, irq} !== 4'b0000)
      $display("FAIL rstrun_pulses got %b want 0000", {fft_start, fft_abort, fft_done, irq}); else passed++;
    rst = 1'b0;
    gpr_ctrl = '0;
    step();
    total++; if (fft_abort !== 1'b0 || status !== 16'h0000)
      $display("FAIL rstrun_after got abort=%b st=%h want 0/0000", fft_abort, status); else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_host_gating();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencer for one FFT job through the DSP memory map. Watches the host-written GPR control word and launches the FFT core only after the input registers have settled. It then waits for the core with a timeout and issues the one-cycle capture pulse (`fft_done`) that loads results into the memory map. It also gates host writes on the shared memory-map port, so inputs stay stable during a run and a host write can never mask the capture cycle (the memory map gives `write_en` priority over `fft_done`).

## Interface
- `DATA_WIDTH`, 16, register word width; must be ≥ 16.
- `ADDR_WIDTH`, 6, memory-map address width.
- `FFT_IN_BASE`, 31, word address of the first FFT input register (real, then imag).
- `FFT_IN_REGS`, 16, number of FFT input words protected during a run.
- `SETTLE_CYCLES`, 2, wait between start detection and launch; minimum 1.
- `TIMEOUT_CYCLES`, 1024, RUN-state cycle budget; minimum 2.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `gpr_ctrl`  in  DATA_WIDTH  GPR word 0 from the memory map: bit0 START, bit1 ABORT, bit2 IRQ_EN.
- `host_write_en`  in  1  host write request.
- `host_addr`  in  ADDR_WIDTH  host address.
- `host_stall`  out  1  host must hold its write.
- `mm_write_en`  out  1  gated write enable to the memory map.
- `fft_start`  out  1  one-cycle launch pulse to the FFT core.
- `fft_abort`  out  1  one-cycle abort pulse to the FFT core.
- `core_done`  in  1  one-cycle completion pulse from the FFT core.
- `fft_done`  out  1  one-cycle capture pulse to the memory map.
- `status`  out  DATA_WIDTH  [0] busy, [1] done, [2] timeout, [3] aborted, [7:4] state code, [15:8] run_count, upper bits 0.
- `irq`  out  1  IRQ_EN & (done | timeout | aborted).

## Operation
- START is edge-triggered: a 0→1 transition of `gpr_ctrl[0]` against a registered copy of it. ABORT is level-sensitive.
- States and codes:
  - IDLE=0
  - SETTLE=1
  - LAUNCH=2
  - RUN=3
  - CAPTURE=4
- State transitions:
  - IDLE → SETTLE on a START edge. The same edge clears done, timeout and aborted.
  - SETTLE counts SETTLE_CYCLES, then goes to LAUNCH. ABORT in SETTLE → IDLE with aborted=1; no `fft_abort` pulse, since the core was never started.
  - LAUNCH: `fft_start`=1 for this single cycle, then RUN. The timer is cleared here.
  - RUN: on `core_done` → CAPTURE. Otherwise, ABORT → IDLE with `fft_abort` pulsed and aborted=1. Otherwise, when the timer reaches TIMEOUT_CYCLES-1 → IDLE with `fft_abort` pulsed and timeout=1.
  - Priority within RUN: `core_done` > ABORT > timeout.
  - CAPTURE: `fft_done`=1 for one cycle, done=1, run_count+1 (8 bits, wraps 255→0), then IDLE. ABORT is ignored in CAPTURE.
- START edges outside IDLE are ignored; the edge register still updates.
- A START edge coinciding with ABORT in IDLE: ABORT wins and the state stays IDLE.
- Host-write gating, combinational:
  - Stall when `host_write_en` & (state==CAPTURE | (state≠IDLE & FFT_IN_BASE ≤ `host_addr` < FFT_IN_BASE+FFT_IN_REGS)).
  - `mm_write_en` = `host_write_en` & ~`host_stall`.
  - Writes to GPR, coefficient and output regions pass freely except in CAPTURE. This keeps ABORT writes possible during a run.
- busy = (state≠IDLE).
- `fft_start`, `fft_abort` and `fft_done` are registered, state-decoded pulses.

## Timing
- Reset values:
  - state IDLE
  - all sticky bits 0
  - run_count 0
  - `fft_start`, `fft_abort`, `fft_done`, `irq` = 0
  - `status` = 0
  - START edge register 0
  - `host_stall`/`mm_write_en` follow their combinational definitions.
- Reset mid-job returns to IDLE the next cycle with no `fft_abort` pulse. The core is reset by the same `rst`.
- START edge detected in cycle N: SETTLE from N+1, LAUNCH at N+1+SETTLE_CYCLES, RUN from one cycle later.
- `core_done` in cycle M (in RUN): `fft_done` high in M+1, status done=1 and IDLE visible in M+2.
- Timeout: RUN lasts exactly TIMEOUT_CYCLES cycles; the `fft_abort` pulse follows in the next cycle.
- Stall-to-release latency is 0 cycles: `mm_write_en` rises in the first IDLE cycle.

## Structure
- Package `fft_seq_pkg` holds:
  - the state enum with its fixed encodings,
  - GPR bit indices (START, ABORT, IRQ_EN),
  - status field positions,
  - the run_count width (8).
- One sub-module, `seq_timer`: a loadable up-counter with a terminal-count flag, instantiated once. SETTLE and RUN share it and it is cleared on every state entry.
- Everything else lives in `fft_seq_ctrl`.

## Test plan
- Normal job, SETTLE_CYCLES=2: START edge at cycle 10 → `fft_start` at 13; `core_done` at 20 → `fft_done` at 21, status=0x0102 (run_count 1, done) at 22; `irq`=1 iff IRQ_EN.
- Host write to address 35 during RUN → `host_stall`=1, `mm_write_en`=0 until IDLE; a write to address 5 in RUN passes unstalled; any write during CAPTURE is stalled.
- No `core_done`, TIMEOUT_CYCLES=8 → RUN for 8 cycles, `fft_abort` pulse, status timeout=1, `fft_done` never asserted.
- ABORT written during RUN → `fft_abort` one cycle, aborted=1, IDLE; ABORT in SETTLE → aborted=1 with no `fft_start` and no `fft_abort`.
- `core_done` and ABORT in the same RUN cycle → capture path taken, done=1, aborted=0; a START edge during RUN is ignored and run_count increments only once.
- 256 successful jobs → run_count wraps to 0.
- `rst` asserted in RUN → next-cycle status=0 and all pulses 0.
